// File: rtl/mfa_pkg.sv
// Shared types and sizing helpers for the box-count pyramid scheduler.
package mfa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Level register width; kept at least 1 bit so a single-level pyramid still elaborates.
    function automatic int lvl_w(input int box_idx);
        return (box_idx > 1) ? $clog2(box_idx) : 1;
    endfunction

    // sqg sweeps the full grid each level, emitting one write per 2x2 box.
    function automatic int wr_per_lvl(input int box_idx);
        return 1 << (2 * (box_idx - 1));
    endfunction

    // Side of the meaningful output region at level lvl.
    function automatic int valid_side(input int box_idx, input int lvl);
        return 1 << (box_idx - 1 - lvl);
    endfunction

endpackage

// File: rtl/bc_nz_counter.sv
// Counts nonzero box-count writes landing inside the valid region of the current level.
// Count updates the cycle after each qualifying write; clears in ARM, held until the next ARM.
module bc_nz_counter
    import mfa_pkg::*;
#(
    parameter int BOX_IDX = 3,
    parameter int CW      = 8,
    parameter int LVL_W   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_drain,
    input  logic                   i_wen,
    input  logic [LVL_W-1:0]       i_level,
    input  logic [2*BOX_IDX-1:0]   i_wr_addr,
    input  logic [CW-1:0]          i_wr_data,
    output logic [2*BOX_IDX-2:0]   o_nz_count,
    output logic                   o_stats_valid
);

    localparam int SW = BOX_IDX + 1;

    logic [SW-1:0]          w_side;
    logic [SW-1:0]          w_x;
    logic [SW-1:0]          w_y;
    logic                   w_hit;
    logic [2*BOX_IDX-2:0]   r_cnt;

    assign w_side = SW'(valid_side(BOX_IDX, int'(i_level)));
    assign w_x    = {1'b0, i_wr_addr[2*BOX_IDX-1:BOX_IDX]};
    assign w_y    = {1'b0, i_wr_addr[BOX_IDX-1:0]};
    assign w_hit  = i_wen && (i_wr_data != '0) && (w_x < w_side) && (w_y < w_side);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_nz_count    = r_cnt;
    assign o_stats_valid = i_drain;

endmodule

// File: rtl/bc_level_sched.sv
// Steps the sqg box-sum engine through every pyramid level, ping-ponging two RAM banks.
// start is accepted only in IDLE; per-level stats are built only when LVL_STATS_EN is defined.
module bc_level_sched
    import mfa_pkg::*;
#(
    parameter int BOX_IDX = 3,
    parameter int CW      = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [lvl_w(BOX_IDX)-1:0]   o_level,
    output logic                        o_sqg_hold,
    output logic                        o_rd_bank,
    input  logic                        i_wen_sqg,
    input  logic [2*BOX_IDX-1:0]        i_wr_addr,
    input  logic [CW-1:0]               i_wr_data,
    output logic                        o_wen_bank0,
    output logic                        o_wen_bank1
`ifdef LVL_STATS_EN
    ,
    output logic [2*BOX_IDX-2:0]        o_nz_count,
    output logic                        o_stats_valid
`endif
);

    localparam int                LVL_W    = lvl_w(BOX_IDX);
    localparam int                CNT_W    = 2 * BOX_IDX - 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(wr_per_lvl(BOX_IDX) - 1);
    localparam logic [LVL_W-1:0]  LVL_LAST = LVL_W'(BOX_IDX - 1);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_sqg_hold;
    logic               r_rd_bank;
    logic [LVL_W-1:0]   r_level;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic               w_run_wen;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sqg_hold <= 1'b1;
            r_rd_bank  <= 1'b0;
            r_level    <= '0;
            r_wr_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state   <= ST_ARM;
                        r_busy    <= 1'b1;
                        r_level   <= '0;
                        r_rd_bank <= 1'b0;
                    end
                end
                ST_ARM: begin
                    r_wr_cnt   <= '0;
                    r_sqg_hold <= 1'b0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    // Counter stops at the terminal count; the last write moves us to DRAIN instead.
                    if (i_wen_sqg) begin
                        if (r_wr_cnt == CNT_LAST) begin
                            r_state    <= ST_DRAIN;
                            r_sqg_hold <= 1'b1;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_level == LVL_LAST) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_level   <= r_level + 1'b1;
                        r_rd_bank <= ~r_rd_bank;
                        r_state   <= ST_ARM;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Writes always target the bank sqg is not reading; strobes outside RUN are dropped.
    assign w_run_wen   = i_wen_sqg && (r_state == ST_RUN);
    assign o_wen_bank1 = w_run_wen && !r_rd_bank;
    assign o_wen_bank0 = w_run_wen && r_rd_bank;

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_level    = r_level;
    assign o_sqg_hold = r_sqg_hold;
    assign o_rd_bank  = r_rd_bank;

`ifdef LVL_STATS_EN
    bc_nz_counter #(
        .BOX_IDX (BOX_IDX),
        .CW      (CW),
        .LVL_W   (LVL_W)
    ) u_nz_counter (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clr         (r_state == ST_ARM),
        .i_drain       (r_state == ST_DRAIN),
        .i_wen         (w_run_wen),
        .i_level       (r_level),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_nz_count    (o_nz_count),
        .o_stats_valid (o_stats_valid)
    );
`else
    logic w_unused_wr;
    assign w_unused_wr = ^{i_wr_addr, i_wr_data};
`endif

endmodule

// File: tb/tb_bc_level_sched.sv
// Directed bench for bc_level_sched at BOX_IDX=3 with a behavioural sqg write generator.
module tb_bc_level_sched;

    localparam int BOX_IDX = 3;
    localparam int CW      = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy, done, sqg_hold, rd_bank, wen_b0, wen_b1;
    logic [1:0]   level;
    logic         wen_sqg;
    logic [5:0]   wr_addr;
    logic [7:0]   wr_data;
`ifdef LVL_STATS_EN
    logic [4:0]   nz_count;
    logic         stats_valid;
`endif

    logic         mwen;
    logic         force_wen;
    int           ph, k;
    int           n_asrt, n_fail;
    int           b0_cnt [4];
    int           b1_cnt [4];
    int           done_cnt, sv_cnt;
    int           nz_cap [4];
    bit           got;

    always #5 clk = ~clk;

    assign wen_sqg = mwen | force_wen;

    bc_level_sched #(.BOX_IDX(BOX_IDX), .CW(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .o_level      (level),
        .o_sqg_hold   (sqg_hold),
        .o_rd_bank    (rd_bank),
        .i_wen_sqg    (wen_sqg),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_wen_bank0  (wen_b0),
        .o_wen_bank1  (wen_b1)
`ifdef LVL_STATS_EN
        ,
        .o_nz_count   (nz_count),
        .o_stats_valid(stats_valid)
`endif
    );

    // sqg stand-in: while released, strobe every 4th cycle sweeping a 4x4 address grid.
    always @(negedge clk) begin
        if (rst || sqg_hold) begin
            ph = 0; mwen = 1'b0; k = 0;
        end else begin
            ph   = (ph + 1) % 4;
            mwen = (ph == 3);
            if (mwen) begin
                wr_addr = {1'b0, k[3:2], 1'b0, k[1:0]};
                case (level)
                    2'd0:    wr_data = 8'(k);
                    2'd1:    wr_data = (k[3:2] == k[1:0] && k[3:2] != 2'd2) ? 8'h05 : 8'h00;
                    default: wr_data = 8'(k + 1);
                endcase
                k++;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (wen_b0) b0_cnt[level]++;
            if (wen_b1) b1_cnt[level]++;
            if (done)   done_cnt++;
`ifdef LVL_STATS_EN
            if (stats_valid) begin
                sv_cnt++;
                nz_cap[level] = int'(nz_count);
            end
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_asrt = 0; n_fail = 0; done_cnt = 0; sv_cnt = 0;
        foreach (b0_cnt[i]) begin b0_cnt[i] = 0; b1_cnt[i] = 0; nz_cap[i] = 0; end
        rst = 1'b1; start = 1'b0; force_wen = 1'b0; mwen = 1'b0;
        wr_addr = '0; wr_data = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold",  32'(sqg_hold), 32'd1);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_bank",  32'(rd_bank),  32'd0);
        check("rst_level", 32'(level),    32'd0);
        check("rst_wen",   32'({wen_b0, wen_b1}), 32'd0);
        rst = 1'b0;

        @(negedge clk);
        force_wen = 1'b1; #1;
        check("idle_wen", 32'({wen_b0, wen_b1}), 32'd0);
        force_wen = 1'b0;

        // First full run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("arm_busy",  32'(busy),     32'd1);
        check("arm_hold",  32'(sqg_hold), 32'd1);
        check("arm_level", 32'(level),    32'd0);
        force_wen = 1'b1; #1;
        check("arm_wen", 32'({wen_b0, wen_b1}), 32'd0);
        force_wen = 1'b0;

        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b1_cnt[0] == 16) begin got = 1; break; end
        end
        check("l0_wait", 32'(got), 32'd1);
        check("drain_hold", 32'(sqg_hold), 32'd1);
        force_wen = 1'b1; #1;
        check("drain_wen", 32'({wen_b0, wen_b1}), 32'd0);
        force_wen = 1'b0;
`ifdef LVL_STATS_EN
        check("drain_sv", 32'(stats_valid), 32'd1);
        check("l0_nz",    32'(nz_count),    32'd15);
`endif

        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (level == 2'd1 && !sqg_hold) begin got = 1; break; end
        end
        check("l1_wait", 32'(got), 32'd1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_level", 32'(level),    32'd1);
        check("restart_bank",  32'(rd_bank),  32'd1);
        check("restart_busy",  32'(busy),     32'd1);
        check("restart_hold",  32'(sqg_hold), 32'd0);

        got = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        check("done_seen", 32'(got),      32'd1);
        check("done_busy", 32'(busy),     32'd0);
        check("done_hold", 32'(sqg_hold), 32'd1);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);

        check("l0_b1", 32'(b1_cnt[0]), 32'd16);
        check("l0_b0", 32'(b0_cnt[0]), 32'd0);
        check("l1_b0", 32'(b0_cnt[1]), 32'd16);
        check("l1_b1", 32'(b1_cnt[1]), 32'd0);
        check("l2_b1", 32'(b1_cnt[2]), 32'd16);
        check("l2_b0", 32'(b0_cnt[2]), 32'd0);
        check("done_cnt", 32'(done_cnt), 32'd1);
`ifdef LVL_STATS_EN
        check("sv_cnt", 32'(sv_cnt),    32'd3);
        check("l1_nz",  32'(nz_cap[1]), 32'd2);
        check("l2_nz",  32'(nz_cap[2]), 32'd1);
`endif

        // Second run, aborted by reset while level 1 is running.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (level == 2'd1 && !sqg_hold) begin got = 1; break; end
        end
        check("abort_wait", 32'(got), 32'd1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_hold",  32'(sqg_hold), 32'd1);
        check("abort_busy",  32'(busy),     32'd0);
        check("abort_level", 32'(level),    32'd0);
        check("abort_bank",  32'(rd_bank),  32'd0);
        check("abort_done",  32'(done),     32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_done_cnt", 32'(done_cnt), 32'd1);
        check("abort_idle_busy", 32'(busy),     32'd0);
        check("abort_idle_hold", 32'(sqg_hold), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
